// File: rtl/cpu_pkg.sv
// Shared MiniCPU definitions: bus widths, fetch FSM encoding and reset constants.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 12;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned OPD_W   = 8;

    localparam logic [ADDR_W-1:0]  RESET_PC  = '0;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 12'h000;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCapture,
        StValid,
        StHalted
    } fetch_state_e;

endpackage

// File: rtl/program_counter.sv
// Program counter register: synchronous clear, load, increment or hold.
module program_counter
    import cpu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    // Increment wraps modulo 2^ADDR_W without a carry flag.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_addr;
        end else if (i_inc) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, synchronous memory read, instruction register and
// valid/ready hand-off to decode, with jump redirect and sticky halt.
module instr_fetch
    import cpu_pkg::*;
(
    input  logic               Clk,
    input  logic               Rst_n,
    output logic [ADDR_W-1:0]  Mem_Addr,
    output logic               Mem_Rd,
    input  logic [INSTR_W-1:0] Mem_Data,
    output logic [INSTR_W-1:0] Instr,
    output logic               Instr_Valid,
    input  logic               Instr_Ready,
    input  logic               Jump,
    input  logic [ADDR_W-1:0]  Jump_Addr,
    input  logic               Halt,
    output logic [ADDR_W-1:0]  PC
);

    fetch_state_e       r_state;
    fetch_state_e       w_state_next;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  w_pc;
    logic               w_capture;
    logic               w_pc_load;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_pc_load    = 1'b0;
        unique case (r_state)
            StIdle:    w_state_next = StFetch;
            StFetch:   w_state_next = StCapture;
            StCapture: begin
                w_state_next = StValid;
                w_capture    = 1'b1;
            end
            StValid:   if (Instr_Ready) w_state_next = StFetch;
            StHalted:  w_state_next = StHalted;
            default:   w_state_next = StIdle;
        endcase
        // A redirect drops whatever word is in flight or held and refetches.
        if (Jump && (r_state inside {StFetch, StCapture, StValid})) begin
            w_state_next = StFetch;
            w_capture    = 1'b0;
            w_pc_load    = 1'b1;
        end
        if (Halt) begin
            w_state_next = StHalted;
            w_capture    = 1'b0;
            w_pc_load    = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_instr <= NOP_INSTR;
        end else if (w_capture) begin
            r_instr <= Mem_Data;
        end
    end

    program_counter u_pc (
        .i_clk       (Clk),
        .i_clr       (!Rst_n),
        .i_load      (w_pc_load),
        .i_load_addr (Jump_Addr),
        .i_inc       (w_capture),
        .o_pc        (w_pc)
    );

    // Outputs depend only on registered state and PC.
    assign Mem_Addr    = w_pc;
    assign PC          = w_pc;
    assign Mem_Rd      = (r_state == StFetch);
    assign Instr_Valid = (r_state == StValid);
    assign Instr       = r_instr;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the MiniCPU. It holds the program counter, reads 12-bit instruction words from the synchronous instruction memory, and latches each word into an instruction register. It presents the word on a valid/ready handshake to the bus-splitting decode stage, which separates the 4-bit opcode (bits 11:8) from the 8-bit operand (bits 7:0). It also accepts jump redirects from execute and a halt request.

## Interface

- ADDR_W, 8, program counter / memory address width
- INSTR_W, 12, instruction word width (opcode 11:8, operand 7:0)

- Clk  in  1  system clock; all state changes on rising edge
- Rst_n  in  1  reset, synchronous, active-low
- Mem_Addr  out  ADDR_W  instruction memory address, equals PC
- Mem_Rd  out  1  memory read strobe; data returns on Mem_Data exactly one cycle later
- Mem_Data  in  INSTR_W  instruction memory read data
- Instr  out  INSTR_W  instruction register, goes to the bus splitter
- Instr_Valid  out  1  Instr holds an unconsumed instruction
- Instr_Ready  in  1  consumer accepts Instr this cycle
- Jump  in  1  redirect request from execute, one-cycle pulse
- Jump_Addr  in  ADDR_W  redirect target
- Halt  in  1  stop fetching; sticky until reset
- PC  out  ADDR_W  current program counter

## Operation

- Reset applies when Rst_n = 0 at a rising edge. All registers return to reset values regardless of state, including mid-fetch and while Instr_Valid is high. Any in-flight Mem_Data is ignored.
- FSM states: IDLE, FETCH, CAPTURE, VALID, HALTED. Reset state is IDLE.
- IDLE -> FETCH unconditionally.
- FETCH: Mem_Rd = 1, Mem_Addr = PC.
  - Halt -> HALTED.
  - Otherwise -> CAPTURE.
- CAPTURE: Instr <= Mem_Data, PC <= PC + 1, then -> VALID.
- VALID: Instr_Valid = 1.
  - Instr_Ready -> FETCH.
  - Otherwise hold, with Instr stable.
- HALTED: Mem_Rd = 0 and Instr_Valid = 0. The block leaves this state only on reset.
- Jump (checked in FETCH, CAPTURE, VALID; Halt low):
  - PC <= Jump_Addr.
  - Any fetched or held word is discarded and Instr_Valid clears next cycle.
  - Next state is FETCH.
  - In CAPTURE, Instr is not updated and PC is not incremented.
  - In VALID, Jump overrides Instr_Ready.
- Priority: Rst_n > Halt > Jump > normal flow. Halt in any state -> HALTED next cycle, and a pending Jump is ignored.
- PC arithmetic is modulo 2^ADDR_W. 8'hFF + 1 = 8'h00 with no flag.
- Mem_Rd, Mem_Addr and Instr_Valid are decoded from the state and registered PC only. There is no combinational path from Instr_Ready, Jump or Halt to any output.

## Timing

- Reset values: PC = 0, Mem_Addr = 0, Mem_Rd = 0, Instr = 12'h000, Instr_Valid = 0, state IDLE.
- After release, the first Mem_Rd is in the 2nd cycle (IDLE takes 1 cycle).
- Latency from Mem_Rd to Instr_Valid is 2 cycles (FETCH, CAPTURE, then VALID).
- Throughput with Instr_Ready held high is 1 instruction per 3 cycles.
- A handshake completes when Instr_Valid && Instr_Ready at the edge. The next Mem_Rd follows in the next cycle.
- Jump to first Mem_Rd at Jump_Addr is 1 cycle.
- Halt to Mem_Rd = 0 and Instr_Valid = 0 is 1 cycle.

## Structure

- The shared package cpu_pkg holds:
  - ADDR_W, INSTR_W, OPC_W = 4, OPD_W = 8
  - fetch state enum
  - constants RESET_PC = 0, NOP_INSTR = 12'h000
- Sub-module program_counter provides sync clear, load (Jump_Addr), increment and hold. The enables come from the FSM in instr_fetch.

## Test plan

- Memory preloaded 0:12'hA12, 1:12'h3FF, 2:12'h04C; reset, then Ready = 1 -> Instr sequence A12, 3FF, 04C; Instr_Valid high in cycles 4, 7, 10 after release.
- Ready = 0 for 5 cycles in VALID with Instr = 12'hA12 -> Instr, PC and Instr_Valid stable; no Mem_Rd issued.
- Jump, Jump_Addr = 8'h40, asserted in CAPTURE of address 1 -> word at 1 never valid; next Mem_Addr = 8'h40; PC reads 8'h41 after that capture.
- PC = 8'hFF, fetch completes -> PC = 8'h00; next Mem_Addr = 8'h00.
- Halt in VALID -> Instr_Valid = 0 next cycle; Mem_Rd stays 0 for 20 cycles; Jump and Ready ignored.
- Rst_n low for 1 cycle during CAPTURE -> all outputs at reset values next cycle; first Mem_Rd at address 0 two cycles after release.
